// File: rtl/mult_fp_pkg.sv
// Shared parameters and width helpers for the pipelined floating-point multiplier.
// Format: {sign, biased exponent, stored mantissa}; the leading 1 is hidden and exponent 0 means zero.
package mult_fp_pkg;

    localparam int NB_E_DEF = 4;
    localparam int NB_M_DEF = 8;

    typedef enum logic {
        RND_TRUNC   = 1'b0,
        RND_HALF_UP = 1'b1
    } rnd_mode_e;

    function automatic int bias(input int nb_e);
        return (1 << (nb_e - 1)) - 1;
    endfunction

    function automatic int exp_max(input int nb_e);
        return (1 << nb_e) - 1;
    endfunction

    // Two extra bits let the exponent sum carry both a sign and an overflow margin.
    function automatic int exp_sum_width(input int nb_e);
        return nb_e + 2;
    endfunction

    function automatic int prod_width(input int nb_m);
        return 2 * nb_m + 2;
    endfunction

    localparam int BIAS_DEF    = bias(NB_E_DEF);
    localparam int EXP_MAX_DEF = exp_max(NB_E_DEF);

endpackage

// File: rtl/fp_norm_round.sv
// Combinational normalise-and-round step: aligns the raw mantissa product,
// rounds on the guard bit and folds a rounding carry back into the exponent.
module fp_norm_round
    import mult_fp_pkg::*;
#(
    parameter int NB_E = NB_E_DEF,
    parameter int NB_M = NB_M_DEF
) (
    input  logic [prod_width(NB_M)-1:0]    prod,
    input  logic [exp_sum_width(NB_E)-1:0] exp_in,
    input  logic                           rnd,
    output logic [NB_M-1:0]                mant,
    output logic [exp_sum_width(NB_E)-1:0] exp_out
);

    localparam int EW = exp_sum_width(NB_E);
    localparam int PW = prod_width(NB_M);

    logic          norm;
    logic [PW-1:0] aligned;
    logic [NB_M-1:0] frac;
    logic          guard;
    logic          inc;
    logic [NB_M:0] rounded;
    logic          carry;
    logic          unused_bits;

    // A product in [2,4) is shifted down one place so the hidden bit always sits at bit 2*NB_M.
    always_comb begin
        norm    = prod[PW-1];
        aligned = norm ? (prod >> 1) : prod;
        frac    = aligned[PW-3 -: NB_M];
        guard   = aligned[NB_M-1];
        inc     = guard && (rnd_mode_e'(rnd) == RND_HALF_UP);
        rounded = {1'b0, frac} + {{NB_M{1'b0}}, inc};
        carry   = rounded[NB_M];
        mant    = rounded[NB_M-1:0];
        exp_out = exp_in + EW'(norm) + EW'(carry);
    end

    assign unused_bits = ^{aligned[PW-1:PW-2], aligned[NB_M-2:0]};

endmodule

// File: rtl/mult_fp_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow control,
// selectable rounding, overflow/underflow flags and a saturating flag counter.
module mult_fp_pipe
    import mult_fp_pkg::*;
#(
    parameter int NB_E   = NB_E_DEF,
    parameter int NB_M   = NB_M_DEF,
    parameter int NB_S   = 1,
    parameter int NB_IN  = NB_S + NB_E + NB_M,
    parameter int NB_CNT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NB_IN-1:0]  x_A,
    input  logic [NB_IN-1:0]  x_B,
    input  logic              rnd_mode,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [NB_IN-1:0]  y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              ovf,
    output logic              unf,
    input  logic              cnt_clr,
    output logic [NB_CNT-1:0] sat_cnt
);

    localparam int NB_OUT  = NB_IN;
    localparam int EW      = exp_sum_width(NB_E);
    localparam int PW      = prod_width(NB_M);
    localparam int BIAS    = bias(NB_E);
    localparam int EXP_MAX = exp_max(NB_E);

    localparam logic        [EW-1:0] BIAS_V    = EW'(BIAS);
    localparam logic signed [EW-1:0] EXP_MAX_S = EW'(EXP_MAX);
    localparam logic signed [EW-1:0] EXP_MIN_S = EW'(1);

    logic            sign_a, sign_b;
    logic [NB_E-1:0] exp_a, exp_b;
    logic [NB_M-1:0] man_a, man_b;
    logic            en;
    logic            accept;

    logic            s1_valid, s1_sign, s1_zero, s1_rnd;
    logic [EW-1:0]   s1_exp;
    logic [PW-1:0]   s1_prod;

    logic [NB_M-1:0] nr_mant;
    logic [EW-1:0]   nr_exp;

    logic                   s2_valid, s2_sign, s2_zero;
    logic [NB_M-1:0]        s2_mant;
    logic signed [EW-1:0]   s2_exp;

    logic [NB_OUT-1:0] y_next;
    logic              ovf_next, unf_next;

    assign sign_a = x_A[NB_IN-1];
    assign sign_b = x_B[NB_IN-1];
    assign exp_a  = x_A[NB_M +: NB_E];
    assign exp_b  = x_B[NB_M +: NB_E];
    assign man_a  = x_A[NB_M-1:0];
    assign man_b  = x_B[NB_M-1:0];

    // Every stage moves together; a stalled output freezes the whole pipe, bubbles included.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && in_ready;

    // Stage 1: sign, zero detect, biased exponent sum and full mantissa product.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_rnd   <= 1'b0;
            s1_exp   <= '0;
            s1_prod  <= '0;
        end else if (en) begin
            s1_valid <= accept;
            s1_sign  <= sign_a ^ sign_b;
            s1_zero  <= (exp_a == '0) || (exp_b == '0);
            s1_rnd   <= rnd_mode;
            s1_exp   <= EW'(exp_a) + EW'(exp_b) - BIAS_V;
            s1_prod  <= PW'({1'b1, man_a}) * PW'({1'b1, man_b});
        end
    end

    fp_norm_round #(
        .NB_E (NB_E),
        .NB_M (NB_M)
    ) u_norm_round (
        .prod    (s1_prod),
        .exp_in  (s1_exp),
        .rnd     (s1_rnd),
        .mant    (nr_mant),
        .exp_out (nr_exp)
    );

    // Stage 2: capture the normalised, rounded mantissa and its final exponent.
    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_zero  <= 1'b0;
            s2_mant  <= '0;
            s2_exp   <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_zero  <= s1_zero;
            s2_mant  <= nr_mant;
            s2_exp   <= nr_exp;
        end
    end

    // Exponents above the field saturate to the largest magnitude; below 1 flush to zero.
    always_comb begin
        y_next   = '0;
        ovf_next = 1'b0;
        unf_next = 1'b0;
        if (!s2_zero) begin
            if (s2_exp > EXP_MAX_S) begin
                y_next   = {s2_sign, {(NB_OUT-1){1'b1}}};
                ovf_next = 1'b1;
            end else if (s2_exp < EXP_MIN_S) begin
                unf_next = 1'b1;
            end else begin
                y_next = {s2_sign, s2_exp[NB_E-1:0], s2_mant};
            end
        end
    end

    // Stage 3: output registers hold while the consumer stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            y         <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else if (en) begin
            out_valid <= s2_valid;
            y         <= y_next;
            ovf       <= ovf_next;
            unf       <= unf_next;
        end
    end

    // Counts delivered flagged results; a clear in the same cycle takes priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            sat_cnt <= '0;
        end else if (cnt_clr) begin
            sat_cnt <= '0;
        end else if (out_valid && out_ready && (ovf || unf) && (sat_cnt != '1)) begin
            sat_cnt <= sat_cnt + NB_CNT'(1);
        end
    end

endmodule

// File: tb/tb_mult_fp_pipe.sv
// Scoreboard bench for mult_fp_pipe: expected results are queued at acceptance
// and compared in order as the pipeline delivers them.
module tb_mult_fp_pipe;

    localparam int NB_E   = 4;
    localparam int NB_M   = 8;
    localparam int NB_IN  = 13;
    localparam int NB_CNT = 8;

    typedef struct packed {
        logic [NB_IN-1:0] y;
        logic             ovf;
        logic             unf;
    } result_t;

    logic              clock;
    logic              reset;
    logic [NB_IN-1:0]  x_A, x_B;
    logic              rnd_mode;
    logic              in_valid;
    logic              in_ready;
    logic [NB_IN-1:0]  y;
    logic              out_valid;
    logic              out_ready;
    logic              ovf, unf;
    logic              cnt_clr;
    logic [NB_CNT-1:0] sat_cnt;

    result_t sb[$];
    int      num_checks = 0;
    int      num_fail   = 0;
    int      num_out    = 0;
    bit      rand_done;

    mult_fp_pipe #(
        .NB_E   (NB_E),
        .NB_M   (NB_M),
        .NB_CNT (NB_CNT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .x_A       (x_A),
        .x_B       (x_B),
        .rnd_mode  (rnd_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf),
        .unf       (unf),
        .cnt_clr   (cnt_clr),
        .sat_cnt   (sat_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        num_checks++;
        if (got !== want) begin
            num_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Reference multiply on integers: hidden-bit product, normalise, guard rounding, clamp.
    function automatic result_t model(input logic [NB_IN-1:0] a, input logic [NB_IN-1:0] b, input logic rnd);
        result_t r;
        int ea, eb, e, p, shift, mant;
        logic s;
        r  = '0;
        ea = int'(a[11:8]);
        eb = int'(b[11:8]);
        if (ea == 0 || eb == 0) return r;
        s     = a[12] ^ b[12];
        e     = ea + eb - 7;
        p     = (256 + int'(a[7:0])) * (256 + int'(b[7:0]));
        shift = (p >= 131072) ? 9 : 8;
        if (shift == 9) e++;
        mant = p >> shift;
        if (rnd && (((p >> (shift - 1)) & 1) == 1)) mant++;
        if (mant == 512) begin
            mant = 256;
            e++;
        end
        if (e > 15) begin
            r.y   = {s, 12'hFFF};
            r.ovf = 1'b1;
        end else if (e < 1) begin
            r.unf = 1'b1;
        end else begin
            r.y = {s, 4'(e), 8'(mant - 256)};
        end
        return r;
    endfunction

    // Presents one operand pair until accepted, then queues its expected result.
    task automatic applyStimulus(input logic [NB_IN-1:0] a, input logic [NB_IN-1:0] b,
                                 input logic rnd, input result_t want);
        int waited = 0;
        bit got    = 1'b0;
        x_A      = a;
        x_B      = b;
        rnd_mode = rnd;
        in_valid = 1'b1;
        while (!got && waited < 50) begin
            @(negedge clock);
            got = in_ready;
            if (got) sb.push_back(want);
            @(posedge clock);
            #2;
            waited++;
        end
        in_valid = 1'b0;
        if (!got) checkOutput("accept_timeout", 32'(got), 1);
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clock);
            w++;
        end
        checkOutput("drain_empty", sb.size(), 0);
        @(posedge clock);
        #2;
    endtask

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            result_t e;
            num_out++;
            checkOutput("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput("y", 32'(y), 32'(e.y));
                checkOutput("ovf", 32'(ovf), 32'(e.ovf));
                checkOutput("unf", 32'(unf), 32'(e.unf));
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        bit seen;
        int n_before;
        reset     = 1'b1;
        x_A       = '0;
        x_B       = '0;
        rnd_mode  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        rand_done = 1'b0;

        // Operands offered during reset must not produce anything.
        @(posedge clock);
        #2;
        x_A      = 13'b0101011000000;
        x_B      = 13'b1101100000000;
        in_valid = 1'b1;
        repeat (2) begin
            @(posedge clock);
            #2;
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        checkOutput("rst_y", 32'(y), 0);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_ovf", 32'(ovf), 0);
        checkOutput("rst_unf", 32'(unf), 0);
        checkOutput("rst_sat_cnt", 32'(sat_cnt), 0);
        checkOutput("rst_in_ready", 32'(in_ready), 1);
        repeat (3) begin
            @(negedge clock);
            checkOutput("ignored_in_reset", 32'(out_valid), 0);
        end
        @(posedge clock);
        #2;

        $display("[TB] latency and basic products");
        x_A      = 13'b0101011000000;
        x_B      = 13'b1101100000000;
        rnd_mode = 1'b0;
        in_valid = 1'b1;
        @(negedge clock);
        checkOutput("in_ready_idle", 32'(in_ready), 1);
        sb.push_back(result_t'({13'b1111011000000, 1'b0, 1'b0}));
        @(posedge clock);
        #2;
        in_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 10) begin
            @(negedge clock);
            lat++;
            seen = out_valid;
        end
        checkOutput("latency", lat, 3);
        @(posedge clock);
        #2;

        applyStimulus(13'b0001100000000, 13'b1110010010101, 1'b0, result_t'({13'b1100010010101, 1'b0, 1'b0}));
        applyStimulus(13'b0111010111100, 13'b0011111111110, 1'b0, result_t'({13'b0111110111010, 1'b0, 1'b0}));
        applyStimulus(13'b0101011100000, 13'b0000000000000, 1'b0, result_t'({13'b0000000000000, 1'b0, 1'b0}));
        drain();

        $display("[TB] overflow, underflow and counter");
        applyStimulus(13'b0111111111111, 13'b0111111111110, 1'b0, result_t'({13'b0111111111111, 1'b1, 1'b0}));
        drain();
        @(negedge clock);
        checkOutput("sat_cnt_after_ovf", 32'(sat_cnt), 1);
        @(posedge clock);
        #2;
        applyStimulus(13'b0001100000000, 13'b0001100000000, 1'b0, result_t'({13'b0000000000000, 1'b0, 1'b1}));
        drain();
        @(negedge clock);
        checkOutput("sat_cnt_after_unf", 32'(sat_cnt), 2);
        @(posedge clock);
        #2;

        $display("[TB] rounding modes");
        applyStimulus(13'b0011100000001, 13'b0011110000000, 1'b0, result_t'({13'b0011110000001, 1'b0, 1'b0}));
        applyStimulus(13'b0011100000001, 13'b0011110000000, 1'b1, result_t'({13'b0011110000010, 1'b0, 1'b0}));
        drain();

        $display("[TB] back-pressure");
        n_before = num_out;
        fork
            begin
                applyStimulus(13'b0101011000000, 13'b1101100000000, 1'b0, result_t'({13'b1111011000000, 1'b0, 1'b0}));
                applyStimulus(13'b0001100000000, 13'b1110010010101, 1'b0, result_t'({13'b1100010010101, 1'b0, 1'b0}));
                applyStimulus(13'b0111010111100, 13'b0011111111110, 1'b0, result_t'({13'b0111110111010, 1'b0, 1'b0}));
                applyStimulus(13'b0011100000001, 13'b0011110000000, 1'b1, result_t'({13'b0011110000010, 1'b0, 1'b0}));
            end
            begin
                int w = 0;
                while (!out_valid && w < 20) begin
                    @(posedge clock);
                    #2;
                    w++;
                end
                checkOutput("stall_start", 32'(out_valid), 1);
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clock);
                    checkOutput("in_ready_stalled", 32'(in_ready), 0);
                    checkOutput("out_valid_held", 32'(out_valid), 1);
                    @(posedge clock);
                    #2;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        checkOutput("stall_delivered", num_out - n_before, 4);

        $display("[TB] counter clear against flagged handshake");
        @(negedge clock);
        checkOutput("sat_cnt_before_clr", 32'(sat_cnt), 2);
        @(posedge clock);
        #2;
        applyStimulus(13'b0111111111111, 13'b0111111111110, 1'b0, result_t'({13'b0111111111111, 1'b1, 1'b0}));
        begin
            int w = 0;
            while (!out_valid && w < 10) begin
                @(negedge clock);
                w++;
            end
        end
        checkOutput("clr_wait", 32'(out_valid), 1);
        cnt_clr = 1'b1;
        @(posedge clock);
        #2;
        cnt_clr = 1'b0;
        @(negedge clock);
        checkOutput("sat_cnt_clr_wins", 32'(sat_cnt), 0);
        @(posedge clock);
        #2;

        $display("[TB] reset with operations in flight");
        applyStimulus(13'b0101011000000, 13'b1101100000000, 1'b0, result_t'({13'b1111011000000, 1'b0, 1'b0}));
        applyStimulus(13'b0001100000000, 13'b1110010010101, 1'b0, result_t'({13'b1100010010101, 1'b0, 1'b0}));
        reset = 1'b1;
        sb.delete();
        repeat (2) begin
            @(negedge clock);
            checkOutput("flush_during_reset", 32'(out_valid), 0);
            @(posedge clock);
            #2;
        end
        reset = 1'b0;
        repeat (5) begin
            @(negedge clock);
            checkOutput("flush_after_reset", 32'(out_valid), 0);
        end
        @(posedge clock);
        #2;

        $display("[TB] random operands with random back-pressure");
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [NB_IN-1:0] a, b;
                    logic r;
                    a = NB_IN'($urandom_range(0, 8191));
                    b = NB_IN'($urandom_range(0, 8191));
                    r = 1'($urandom_range(0, 1));
                    applyStimulus(a, b, r, model(a, b, r));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clock);
                    #2;
                    if (!rand_done) out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("[TB] counter saturation");
        for (int i = 0; i < 260; i++) begin
            applyStimulus(13'b1111111111111, 13'b0111111111111, 1'b0, result_t'({13'b1111111111111, 1'b1, 1'b0}));
        end
        drain();
        @(negedge clock);
        checkOutput("sat_cnt_saturated", 32'(sat_cnt), 255);
        @(posedge clock);
        #2;

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
